frequency_window_sequencer: RTL

// Sequences measurement windows for frequency_analyzer_manager: drives its clear/start/stop

---
 rtl/frequency_window_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/frequency_window_sequencer.sv
// frequency_window_sequencer: sequences clear/start/window/collect/gap measurement windows
// for the frequency analyzer manager and reports run status.
module frequency_window_sequencer #(
    parameter int WINDOW_WIDTH = 32,
    parameter int GAP_WIDTH    = 16,
    parameter int CLEAR_CYCLES = 4,
    parameter int START_CYCLES = 2,
    parameter int IRQ_TIMEOUT  = 1024
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    input  logic [WINDOW_WIDTH-1:0] cfg_window_cycles,
    input  logic [GAP_WIDTH-1:0]    cfg_gap_cycles,
    input  logic [7:0]              cfg_repeat,
    input  logic                    cmd_run,
    input  logic                    cmd_abort,
    input  logic                    analyzer_irq,
    output logic                    analyzer_clear,
    output logic                    analyzer_start,
    output logic                    analyzer_stop,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic [7:0]              window_count
);
    localparam int PW = $clog2((CLEAR_CYCLES > START_CYCLES ? CLEAR_CYCLES : START_CYCLES) + 1);
    localparam int TW = $clog2(IRQ_TIMEOUT + 1);
    localparam int M1 = WINDOW_WIDTH > GAP_WIDTH ? WINDOW_WIDTH : GAP_WIDTH;
    localparam int M2 = M1 > TW ? M1 : TW;
    localparam int CW = M2 > PW ? M2 : PW;

    typedef enum logic [2:0] {IDLE, CLEAR, START, WINDOW, COLLECT, GAP, DONE, ABORT} state_t;

    state_t                  state, next;
    logic [CW-1:0]           cnt, last;
    logic [WINDOW_WIDTH-1:0] win_len;
    logic [GAP_WIDTH-1:0]    gap_len;
    logic [7:0]              rep_len, wc_next;
    logic                    cnt_done, last_win, latch;

    // cnt counts cycles spent in the current state; last is the final cycle index of that state
    always_comb begin
        last = state == CLEAR  ? CW'(CLEAR_CYCLES - 1) :
               state == START  ? CW'(START_CYCLES - 1) :
               state == WINDOW ? CW'(win_len) - CW'(1) :
               state == GAP    ? CW'(gap_len) - CW'(1) : CW'(IRQ_TIMEOUT - 1);
        cnt_done = cnt == last;
        wc_next  = window_count + 8'd1;
        last_win = rep_len != 8'd0 && wc_next == rep_len;
        latch    = state == IDLE && next == CLEAR;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (cmd_run && !cmd_abort) next = CLEAR;
            CLEAR:   if (cnt_done) next = START;
            START:   if (cnt_done) next = WINDOW;
            WINDOW:  if (cnt_done) next = COLLECT;
            COLLECT: if (analyzer_irq) next = last_win ? DONE : gap_len == '0 ? CLEAR : GAP;
                     else if (cnt_done) next = IDLE;
            GAP:     if (cnt_done) next = CLEAR;
            default: next = IDLE;
        endcase
        if (cmd_abort && state != IDLE && state != ABORT) next = ABORT;
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state        <= IDLE;
            cnt          <= '0;
            win_len      <= '0;
            gap_len      <= '0;
            rep_len      <= '0;
            window_count <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state <= next;
            cnt   <= next == state ? cnt + CW'(1) : '0;
            if (latch) begin
                win_len      <= cfg_window_cycles == '0 ? WINDOW_WIDTH'(1) : cfg_window_cycles;
                gap_len      <= cfg_gap_cycles;
                rep_len      <= cfg_repeat;
                window_count <= '0;
                timeout_err  <= 1'b0;
            end
            if (state == COLLECT && next != ABORT && analyzer_irq) window_count <= wc_next;
            if (state == COLLECT && next == IDLE) timeout_err <= 1'b1;
        end
    end

    // abort cycle is the only state driving clear and stop together
    always_comb begin
        analyzer_clear = state == CLEAR || state == ABORT;
        analyzer_start = state == START;
        analyzer_stop  = state == COLLECT || state == ABORT;
        done           = state == DONE;
        busy           = state != IDLE;
    end
endmodule
